// File: rtl/dsm_pkg.sv
// dsm_pkg: shared types, constants and helpers
// for the second-order delta-sigma modulator.
package dsm_pkg;

  localparam int IN_W       = 16;
  localparam int INT_W      = 24;
  localparam int FIFO_DEPTH = 4;
  localparam int SUM_W      = INT_W + 2;
  localparam int CNT_W      = 11;
  localparam int FS         = 32768;

  localparam logic [IN_W-1:0] MID     = 16'h8000;
  localparam logic [IN_W-1:0] CLIP_LO = 16'h199A;
  localparam logic [IN_W-1:0] CLIP_HI = 16'hE666;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    SUM_W'((2 ** (INT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [SUM_W-1:0] FB_POS  = SUM_W'(FS);
  localparam logic signed [SUM_W-1:0] FB_NEG  = -FB_POS;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  typedef struct packed {
    logic                    hit;
    logic signed [INT_W-1:0] v;
  } sat_t;

  typedef struct packed {
    logic            hit;
    logic [IN_W-1:0] v;
  } clip_t;

  function automatic logic [11:0] dec_of(
    input logic [1:0] mode
  );
    logic [11:0] d;
    case (mode)
      2'd0:    d = 12'd256;
      2'd1:    d = 12'd512;
      2'd2:    d = 12'd1024;
      default: d = 12'd2048;
    endcase
    return d;
  endfunction

  function automatic sat_t sat(
    input logic signed [SUM_W-1:0] s
  );
    sat_t r;
    r.hit = 1'b0;
    r.v   = s[INT_W-1:0];
    if (s > SAT_MAX) begin
      r.hit = 1'b1;
      r.v   = SAT_MAX[INT_W-1:0];
    end else if (s < SAT_MIN) begin
      r.hit = 1'b1;
      r.v   = SAT_MIN[INT_W-1:0];
    end
    return r;
  endfunction

  function automatic clip_t clip(
    input logic [IN_W-1:0] d
  );
    clip_t r;
    r.hit = 1'b0;
    r.v   = d;
    if (d < CLIP_LO) begin
      r.hit = 1'b1;
      r.v   = CLIP_LO;
    end else if (d > CLIP_HI) begin
      r.hit = 1'b1;
      r.v   = CLIP_HI;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsm_fifo.sv
// dsm_fifo: small synchronous sample FIFO with
// wrap-bit pointers; no write-to-read bypass.
module dsm_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic         do_push;
  logic         do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rp_q[AW-1:0]];

  // pointer update on accepted push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dsm2_modulator.sv
// dsm2_modulator: 2nd-order delta-sigma modulator,
// 16-bit offset-binary PCM in, 1-bit MDAT out.
module dsm2_modulator
  import dsm_pkg::*;
(
  input  logic            MCLK,
  input  logic            RST,
  input  logic [1:0]      MODE,
  input  logic            EN,
  input  logic [IN_W-1:0] DIN,
  input  logic            DIN_VALID,
  output logic            DIN_READY,
  input  logic            CLR_ERR,
  output logic            MDAT,
  output logic            SREQ,
  output logic            UNDERRUN,
  output logic            OVLD
);

  state_t                  state_q;
  logic [1:0]              mode_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IN_W-1:0]         smp_q;
  logic signed [INT_W-1:0] i1_q;
  logic signed [INT_W-1:0] i2_q;
  logic                    mdat_q;
  logic                    sreq_q;
  logic                    unr_q;
  logic                    unr_d;
  logic                    ovl_q;
  logic                    ovl_d;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [IN_W-1:0]         fifo_dout;
  logic                    push;
  logic                    pop;
  logic                    wrap;
  logic [11:0]             dec_m1;
  clip_t                   cin;

  logic signed [IN_W:0]    x;
  logic signed [SUM_W-1:0] x_w;
  logic signed [SUM_W-1:0] fb_w;
  logic signed [SUM_W-1:0] i1_w;
  logic signed [SUM_W-1:0] i2_w;
  logic signed [SUM_W-1:0] n1_w;
  logic signed [SUM_W-1:0] sum1;
  logic signed [SUM_W-1:0] sum2;
  sat_t                    s1;
  sat_t                    s2;
  logic                    unr_set;
  logic                    ovl_set;

  dsm_fifo #(
    .W     (IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MCLK),
    .rst_n (RST),
    .push  (push),
    .pop   (pop),
    .wdata (DIN),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign DIN_READY = !fifo_full;
  assign MDAT      = mdat_q;
  assign SREQ      = sreq_q;
  assign UNDERRUN  = unr_q;
  assign OVLD      = ovl_q;

  assign push   = DIN_VALID && !fifo_full;
  assign dec_m1 = dec_of(mode_q) - 12'd1;
  assign wrap   = ({1'b0, cnt_q} == dec_m1);
  assign cin    = clip(fifo_dout);

  assign pop = EN && !fifo_empty &&
               ((state_q == PRIME) ||
                ((state_q == RUN) && wrap));

  // loop arithmetic: two saturating integrators
  always_comb begin
    x    = $signed({1'b0, smp_q}) - $signed({1'b0, MID});
    x_w  = {{(SUM_W-IN_W-1){x[IN_W]}}, x};
    fb_w = mdat_q ? FB_POS : FB_NEG;
    i1_w = {{2{i1_q[INT_W-1]}}, i1_q};
    i2_w = {{2{i2_q[INT_W-1]}}, i2_q};
    sum1 = i1_w + x_w - fb_w;
    s1   = sat(sum1);
    n1_w = {{2{s1.v[INT_W-1]}}, s1.v};
    sum2 = i2_w + n1_w - fb_w - fb_w;
    s2   = sat(sum2);
  end

  // sticky flags: a set event beats CLR_ERR
  always_comb begin
    unr_set = EN && (state_q == RUN) &&
              wrap && fifo_empty;
    ovl_set = (pop && cin.hit) ||
              (EN && (state_q == RUN) &&
               (s1.hit || s2.hit));
    unr_d   = unr_set || (unr_q && !CLR_ERR);
    ovl_d   = ovl_set || (ovl_q && !CLR_ERR);
  end

  // flag registers
  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) begin
      unr_q <= 1'b0;
      ovl_q <= 1'b0;
    end else begin
      unr_q <= unr_d;
      ovl_q <= ovl_d;
    end
  end

  // sequencer, sample load and loop state
  always_ff @(posedge MCLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      cnt_q   <= '0;
      smp_q   <= MID;
      i1_q    <= '0;
      i2_q    <= '0;
      mdat_q  <= 1'b0;
      sreq_q  <= 1'b0;
    end else begin
      sreq_q <= 1'b0;
      if (state_q == IDLE) mode_q <= MODE;
      if (!EN) begin
        state_q <= IDLE;
        mdat_q  <= ~mdat_q;
        i1_q    <= '0;
        i2_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            mdat_q  <= ~mdat_q;
            state_q <= PRIME;
          end
          PRIME: begin
            mdat_q <= ~mdat_q;
            if (pop) begin
              smp_q   <= cin.v;
              sreq_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= RUN;
            end
          end
          RUN: begin
            i1_q   <= s1.v;
            i2_q   <= s2.v;
            mdat_q <= ~s2.v[INT_W-1];
            cnt_q  <= wrap ? '0 : cnt_q + CNT_W'(1);
            if (pop) begin
              smp_q  <= cin.v;
              sreq_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
